// File: rtl/eight_mem_pkg.sv
// rtl/eight_mem_pkg.sv - shared address map and state encoding for the eight-bank coefficient memory
package eight_mem_pkg;

  localparam int ADDR_WIDTH       = 12;
  localparam int ADDR_WIDTH_8_MEM = 15;
  localparam int DATA_WIDTH       = 32;
  localparam int LEN_WIDTH        = 16;

  localparam int NUM_BANKS = 8;
  localparam int BANK_BITS = 3;
  localparam int BANK_MSB  = 14;
  localparam int BANK_LSB  = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/eight_mem_bank_dec.sv
// rtl/eight_mem_bank_dec.sv - 3-to-8 one-hot bank select decoder with enable
module eight_mem_bank_dec
  import eight_mem_pkg::*;
(
  input  logic                 en_i,
  input  logic [BANK_BITS-1:0] sel_i,
  output logic [NUM_BANKS-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/eight_mem_cof_loader.sv
// rtl/eight_mem_cof_loader.sv - streams coefficient words into consecutive global addresses of the eight-bank memory
module eight_mem_cof_loader
  import eight_mem_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_WIDTH_8_MEM-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]        length,
  input  logic                        s_valid,
  input  logic [DATA_WIDTH-1:0]       s_data,
  output logic                        s_ready,
  output logic                        cen_0,
  output logic                        cen_1,
  output logic                        cen_2,
  output logic                        cen_3,
  output logic                        cen_4,
  output logic                        cen_5,
  output logic                        cen_6,
  output logic                        cen_7,
  output logic                        wen,
  output logic [ADDR_WIDTH-1:0]       addr_8_mem_out,
  output logic [DATA_WIDTH-1:0]       data_8_mem_out,
  output logic                        busy,
  output logic                        done,
  output logic                        wrapped
);

  state_e                      state_q, state_d;
  logic [ADDR_WIDTH_8_MEM-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]        rem_q, rem_d;
  logic                        wrapped_q, wrapped_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        wen_q, wen_d;
  logic [NUM_BANKS-1:0]        cen_q, cen_d;
  logic [ADDR_WIDTH-1:0]       waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic [ADDR_WIDTH_8_MEM:0]   addr_inc;
  logic                        accept;

  assign s_ready  = (state_q == LOAD) && (rem_q != '0);
  assign accept   = s_valid && s_ready;
  assign addr_inc = {1'b0, addr_q} + {{ADDR_WIDTH_8_MEM{1'b0}}, 1'b1};

  // The bank is decoded from the address being written this beat, then registered with it.
  eight_mem_bank_dec u_bank_dec (
    .en_i     (accept),
    .sel_i    (addr_q[BANK_MSB:BANK_LSB]),
    .onehot_o (cen_d)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    wrapped_d = wrapped_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d    = base_addr;
          rem_d     = length;
          wrapped_d = 1'b0;
          busy_d    = 1'b1;
          if (length == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          wen_d   = 1'b1;
          waddr_d = addr_q[ADDR_WIDTH-1:0];
          wdata_d = s_data;
          addr_d  = addr_inc[ADDR_WIDTH_8_MEM-1:0];
          rem_d   = rem_q - LEN_WIDTH'(1);
          if (addr_inc[ADDR_WIDTH_8_MEM]) begin
            wrapped_d = 1'b1;
          end
          if (rem_q == LEN_WIDTH'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      wrapped_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wen_q     <= 1'b0;
      cen_q     <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      wrapped_q <= wrapped_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wen_q     <= wen_d;
      cen_q     <= cen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign cen_0          = cen_q[0];
  assign cen_1          = cen_q[1];
  assign cen_2          = cen_q[2];
  assign cen_3          = cen_q[3];
  assign cen_4          = cen_q[4];
  assign cen_5          = cen_q[5];
  assign cen_6          = cen_q[6];
  assign cen_7          = cen_q[7];
  assign wen            = wen_q;
  assign addr_8_mem_out = waddr_q;
  assign data_8_mem_out = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign wrapped        = wrapped_q;

endmodule

// File: tb/tb_eight_mem_cof_loader.sv
// tb/tb_eight_mem_cof_loader.sv - scoreboard bench for the eight-bank coefficient loader
module tb_eight_mem_cof_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [14:0] base_addr = '0;
  logic [15:0] length = '0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic        cen_0, cen_1, cen_2, cen_3, cen_4, cen_5, cen_6, cen_7;
  logic        wen;
  logic [11:0] addr_8_mem_out;
  logic [31:0] data_8_mem_out;
  logic        busy, done, wrapped;
  logic [7:0]  cen_v;

  typedef struct packed {
    logic [7:0]  cen;
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_err = 0;

  eight_mem_cof_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .cen_0          (cen_0),
    .cen_1          (cen_1),
    .cen_2          (cen_2),
    .cen_3          (cen_3),
    .cen_4          (cen_4),
    .cen_5          (cen_5),
    .cen_6          (cen_6),
    .cen_7          (cen_7),
    .wen            (wen),
    .addr_8_mem_out (addr_8_mem_out),
    .data_8_mem_out (data_8_mem_out),
    .busy           (busy),
    .done           (done),
    .wrapped        (wrapped)
  );

  assign cen_v = {cen_7, cen_6, cen_5, cen_4, cen_3, cen_2, cen_1, cen_0};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write the DUT presents is popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wen) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(cen_v), 64'h0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_cen", 64'(cen_v), 64'(mon_e.cen));
          check("wr_addr", 64'(addr_8_mem_out), 64'(mon_e.addr));
          check("wr_data", 64'(data_8_mem_out), 64'(mon_e.data));
        end
      end else begin
        check("gap_cen", 64'(cen_v), 64'h0);
      end
    end
  end

  task automatic push_exp(input logic [7:0] c, input logic [11:0] a, input logic [31:0] d);
    wr_t e;
    e.cen  = c;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic start_load(input logic [14:0] b, input logic [15:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic send_beats(input int n, input logic [31:0] d0, input bit gap);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = d0 + 32'(i);
      @(posedge clk); #1;
      if (gap && i < n - 1) begin
        s_valid = 1'b0;
        s_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    check({tag, "_done"}, 64'(done), 64'h1);
    check({tag, "_busy_in_done"}, 64'(busy), 64'h1);
    @(posedge clk); #1;
    check({tag, "_done_pulse_end"}, 64'(done), 64'h0);
    check({tag, "_busy_low"}, 64'(busy), 64'h0);
    check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cen"}, 64'(cen_v), 64'h0);
    check({tag, "_wen"}, 64'(wen), 64'h0);
    check({tag, "_addr"}, 64'(addr_8_mem_out), 64'h0);
    check({tag, "_data"}, 64'(data_8_mem_out), 64'h0);
    check({tag, "_s_ready"}, 64'(s_ready), 64'h0);
    check({tag, "_busy"}, 64'(busy), 64'h0);
    check({tag, "_done"}, 64'(done), 64'h0);
    check({tag, "_wrapped"}, 64'(wrapped), 64'h0);
  endtask

  initial begin
    @(posedge clk); #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Crossing from bank 0 into bank 1.
    push_exp(8'h01, 12'hFFE, 32'hA000_0000);
    push_exp(8'h01, 12'hFFF, 32'hA000_0001);
    push_exp(8'h02, 12'h000, 32'hA000_0002);
    push_exp(8'h02, 12'h001, 32'hA000_0003);
    start_load(15'h0FFE, 16'd4);
    check("t1_busy_after_start", 64'(busy), 64'h1);
    check("t1_s_ready", 64'(s_ready), 64'h1);
    send_beats(4, 32'hA000_0000, 1'b0);
    expect_done("t1");
    check("t1_wrapped", 64'(wrapped), 64'h0);
    @(posedge clk); #1;

    // Wrap past the top of the global address space.
    push_exp(8'h80, 12'hFFF, 32'hB000_0000);
    push_exp(8'h01, 12'h000, 32'hB000_0001);
    start_load(15'h7FFF, 16'd2);
    send_beats(2, 32'hB000_0000, 1'b0);
    expect_done("t2");
    check("t2_wrapped", 64'(wrapped), 64'h1);
    @(posedge clk); #1;

    // Valid toggling: writes only after accepts, gaps idle.
    for (int i = 0; i < 8; i++) push_exp(8'h04, 12'h010 + 12'(i), 32'hC000_0000 + 32'(i));
    start_load(15'h2010, 16'd8);
    send_beats(8, 32'hC000_0000, 1'b1);
    expect_done("t3");
    @(posedge clk); #1;

    // Zero-length load.
    start_load(15'h1234, 16'd0);
    check("t4_wrapped_cleared", 64'(wrapped), 64'h0);
    check("t4_s_ready", 64'(s_ready), 64'h0);
    check("t4_wen", 64'(wen), 64'h0);
    expect_done("t4");
    check("t4_s_ready_after", 64'(s_ready), 64'h0);
    @(posedge clk); #1;

    // Start during LOAD is ignored.
    for (int i = 0; i < 4; i++) push_exp(8'h02, 12'h100 + 12'(i), 32'hD000_0000 + 32'(i));
    start_load(15'h1100, 16'd4);
    send_beats(2, 32'hD000_0000, 1'b0);
    base_addr = 15'h5000;
    length    = 16'd9;
    start     = 1'b1;
    send_beats(2, 32'hD000_0002, 1'b0);
    start     = 1'b0;
    expect_done("t5");
    @(posedge clk); #1;

    // Reset mid-load, then a fresh load from a new base.
    for (int i = 0; i < 3; i++) push_exp(8'h08, 12'h000 + 12'(i), 32'hE000_0000 + 32'(i));
    start_load(15'h3000, 16'd10);
    send_beats(3, 32'hE000_0000, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_reset");
    check("t6_queue_drained", 64'(exp_q.size()), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push_exp(8'h40, 12'hABC + 12'(i), 32'hF000_0000 + 32'(i));
    start_load(15'h6ABC, 16'd3);
    send_beats(3, 32'hF000_0000, 1'b0);
    expect_done("t6");
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
